// File: rtl/pipeline_pkg.sv
// Shared types and widths for the LEGv8 pipeline stages.
package pipeline_pkg;

    localparam int DATA_W = 64;
    localparam int REG_W  = 5;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_RESP = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
        logic branch;
        logic uncond_branch;
    } ex_mem_ctrl_t;

endpackage

// File: rtl/dmem_handshake_fsm.sv
// Request/grant/response handshake with data memory for one load or store.
//
// state     | meaning
// IDLE      | request driven while a memop is held; stores retire on grant
// WAIT_RESP | load granted, waiting for read data
module dmem_handshake_fsm
    import pipeline_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic memop,
    input  logic is_write,
    input  logic dmem_gnt,
    input  logic dmem_rvalid,
    output logic dmem_req,
    output logic dmem_we,
    output logic done,
    output logic capture
);

    mem_state_t state, state_nxt;

    always_comb begin
        state_nxt = state;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        done      = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                dmem_req = memop;
                dmem_we  = memop & is_write;
                if (memop && dmem_gnt) begin
                    if (is_write) done = 1'b1;
                    else          state_nxt = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (dmem_rvalid) begin
                    done      = 1'b1;
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

endmodule

// File: rtl/mem_stage.sv
// LEGv8 memory stage: EX/MEM register, branch resolution, data memory access, MEM/WB register.
module mem_stage
    import pipeline_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic              Zero,
    input  logic [DATA_W-1:0] AddResult,
    input  logic [DATA_W-1:0] StoreData,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic              Branch,
    input  logic              UncondBranch,
    output logic              stall,
    output logic              PCSrc,
    output logic [DATA_W-1:0] BranchTarget,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wb_RegWrite,
    output logic              wb_MemtoReg,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_alu_result,
    output logic [DATA_W-1:0] wb_read_data
);

    logic              m_valid;
    ex_mem_ctrl_t      m_ctrl;
    logic              m_Zero;
    logic [DATA_W-1:0] m_ALUResult;
    logic [DATA_W-1:0] m_AddResult;
    logic [DATA_W-1:0] m_StoreData;
    logic [REG_W-1:0]  m_rd;

    logic m_memop;
    logic done;
    logic capture;

    assign m_memop      = m_valid & (m_ctrl.mem_read | m_ctrl.mem_write);
    assign stall        = m_memop & ~done;
    assign PCSrc        = m_valid & (m_ctrl.uncond_branch | (m_ctrl.branch & m_Zero));
    assign BranchTarget = m_AddResult;
    assign dmem_addr    = m_ALUResult;
    assign dmem_wdata   = m_StoreData;

    // The instruction arriving alongside a taken branch is on the wrong path.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid     <= 1'b0;
            m_ctrl      <= '0;
            m_Zero      <= 1'b0;
            m_ALUResult <= '0;
            m_AddResult <= '0;
            m_StoreData <= '0;
            m_rd        <= '0;
        end else if (!stall) begin
            m_valid     <= ex_valid & ~PCSrc;
            m_ctrl      <= '{mem_read:      MemRead,
                             mem_write:     MemWrite,
                             mem_to_reg:    MemtoReg,
                             reg_write:     RegWrite,
                             branch:        Branch,
                             uncond_branch: UncondBranch};
            m_Zero      <= Zero;
            m_ALUResult <= ALUResult;
            m_AddResult <= AddResult;
            m_StoreData <= StoreData;
            m_rd        <= ex_rd;
        end
    end

    dmem_handshake_fsm u_fsm (
        .clk         (clk),
        .rst         (rst),
        .memop       (m_memop),
        .is_write    (m_ctrl.mem_write),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .done        (done),
        .capture     (capture)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid      <= 1'b0;
            wb_RegWrite   <= 1'b0;
            wb_MemtoReg   <= 1'b0;
            wb_rd         <= '0;
            wb_alu_result <= '0;
            wb_read_data  <= '0;
        end else begin
            wb_valid      <= m_valid & ~stall;
            wb_RegWrite   <= m_valid & ~stall & m_ctrl.reg_write;
            wb_MemtoReg   <= m_ctrl.mem_to_reg;
            wb_rd         <= m_rd;
            wb_alu_result <= m_ALUResult;
            if (capture) wb_read_data <= dmem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a write-back scoreboard.
module tb_mem_stage;
    import pipeline_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_valid;
    logic [DATA_W-1:0] ALUResult, AddResult, StoreData;
    logic              Zero;
    logic [REG_W-1:0]  ex_rd;
    logic              MemRead, MemWrite, MemtoReg, RegWrite, Branch, UncondBranch;
    logic              stall, PCSrc;
    logic [DATA_W-1:0] BranchTarget;
    logic              dmem_req, dmem_we;
    logic [DATA_W-1:0] dmem_addr, dmem_wdata;
    logic              dmem_gnt, dmem_rvalid;
    logic [DATA_W-1:0] dmem_rdata;
    logic              wb_valid, wb_RegWrite, wb_MemtoReg;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_alu_result, wb_read_data;

    typedef struct {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] alu;
        logic              rw;
        logic              m2r;
        logic [DATA_W-1:0] rdata;
    } wb_exp_t;

    wb_exp_t sb[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ALUResult(ALUResult), .Zero(Zero),
        .AddResult(AddResult), .StoreData(StoreData), .ex_rd(ex_rd),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .Branch(Branch), .UncondBranch(UncondBranch), .stall(stall), .PCSrc(PCSrc),
        .BranchTarget(BranchTarget), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
        .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_rd(wb_rd),
        .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data)
    );

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid = 0; ALUResult = '0; Zero = 0; AddResult = '0; StoreData = '0; ex_rd = '0;
        MemRead = 0; MemWrite = 0; MemtoReg = 0; RegWrite = 0; Branch = 0; UncondBranch = 0;
    endtask

    task automatic drive(input logic [DATA_W-1:0] alu, input logic z, input logic [DATA_W-1:0] add,
                         input logic [DATA_W-1:0] sd, input logic [REG_W-1:0] rd,
                         input logic mr, input logic mw, input logic m2r, input logic rw,
                         input logic br, input logic ub);
        ex_valid = 1; ALUResult = alu; Zero = z; AddResult = add; StoreData = sd; ex_rd = rd;
        MemRead = mr; MemWrite = mw; MemtoReg = m2r; RegWrite = rw; Branch = br; UncondBranch = ub;
    endtask

    task automatic push(input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] alu,
                        input logic rw, input logic m2r, input logic [DATA_W-1:0] rdata);
        wb_exp_t e;
        e.rd = rd; e.alu = alu; e.rw = rw; e.m2r = m2r; e.rdata = rdata;
        sb.push_back(e);
    endtask

    // Retire monitor: every valid write-back must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", 64'(wb_valid), 64'd0);
            end else begin
                wb_exp_t e;
                e = sb.pop_front();
                chk("wb_rd", 64'(wb_rd), 64'(e.rd));
                chk("wb_alu_result", wb_alu_result, e.alu);
                chk("wb_RegWrite", 64'(wb_RegWrite), 64'(e.rw));
                chk("wb_MemtoReg", 64'(wb_MemtoReg), 64'(e.m2r));
                if (e.m2r) chk("wb_read_data", wb_read_data, e.rdata);
            end
        end
    end

    initial begin
        clear_ex();
        rst = 1; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = '0;
        step(); step();
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_wb_RegWrite", 64'(wb_RegWrite), 64'd0);
        chk("rst_wb_rd", 64'(wb_rd), 64'd0);
        chk("rst_wb_alu", wb_alu_result, 64'd0);
        chk("rst_wb_rdata", wb_read_data, 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_pcsrc", 64'(PCSrc), 64'd0);
        chk("rst_req", 64'(dmem_req), 64'd0);
        rst = 0;

        // ADD
        drive(64'h10, 0, 0, 0, 5'd3, 0, 0, 0, 1, 0, 0);
        push(5'd3, 64'h10, 1, 0, 0);
        step(); clear_ex();
        chk("add_stall", 64'(stall), 64'd0);
        chk("add_req", 64'(dmem_req), 64'd0);
        step();
        chk("add_wb_valid", 64'(wb_valid), 64'd1);
        chk("add_stall2", 64'(stall), 64'd0);

        // LDUR: grant after two cycles, response three cycles after grant
        drive(64'h40, 0, 0, 0, 5'd5, 1, 0, 1, 1, 0, 0);
        push(5'd5, 64'h40, 1, 1, 64'hDEAD);
        step(); clear_ex();
        for (int i = 0; i < 5; i++) begin
            chk("ld_stall", 64'(stall), 64'd1);
            chk("ld_req", 64'(dmem_req), (i <= 2) ? 64'd1 : 64'd0);
            if (i <= 2) begin
                chk("ld_addr", dmem_addr, 64'h40);
                chk("ld_we", 64'(dmem_we), 64'd0);
            end
            dmem_gnt = (i == 2);
            step();
            dmem_gnt = 0;
        end
        dmem_rvalid = 1; dmem_rdata = 64'hDEAD;
        #1;
        chk("ld_stall_rvalid", 64'(stall), 64'd0);
        step();
        dmem_rvalid = 0; dmem_rdata = '0;
        chk("ld_wb_valid", 64'(wb_valid), 64'd1);
        chk("ld_wb_rdata", wb_read_data, 64'hDEAD);

        // STUR with immediate grant
        drive(64'h80, 0, 0, 64'h1234, 5'd0, 0, 1, 0, 0, 0, 0);
        push(5'd0, 64'h80, 0, 0, 0);
        step(); clear_ex();
        dmem_gnt = 1;
        #1;
        chk("st_req", 64'(dmem_req), 64'd1);
        chk("st_we", 64'(dmem_we), 64'd1);
        chk("st_addr", dmem_addr, 64'h80);
        chk("st_wdata", dmem_wdata, 64'h1234);
        chk("st_stall", 64'(stall), 64'd0);
        step();
        dmem_gnt = 0;
        chk("st_req_drop", 64'(dmem_req), 64'd0);

        // CBZ taken; the following instruction must be squashed
        drive(0, 1, 64'h200, 0, 5'd0, 0, 0, 0, 0, 1, 0);
        push(5'd0, 64'h0, 0, 0, 0);
        step();
        drive(64'h99, 0, 0, 0, 5'd9, 0, 0, 0, 1, 0, 0);
        chk("cbz_pcsrc", 64'(PCSrc), 64'd1);
        chk("cbz_target", BranchTarget, 64'h200);
        chk("cbz_stall", 64'(stall), 64'd0);
        step(); clear_ex();
        chk("cbz_pcsrc_one", 64'(PCSrc), 64'd0);
        step();
        chk("squash_wb_valid", 64'(wb_valid), 64'd0);
        chk("squash_wb_rw", 64'(wb_RegWrite), 64'd0);

        // CBZ not taken
        drive(0, 0, 64'h300, 0, 5'd0, 0, 0, 0, 0, 1, 0);
        push(5'd0, 64'h0, 0, 0, 0);
        step(); clear_ex();
        chk("cbz_nt_pcsrc", 64'(PCSrc), 64'd0);
        step();

        // Reset while waiting for a load response; late rvalid discarded
        drive(64'h50, 0, 0, 0, 5'd4, 1, 0, 1, 1, 0, 0);
        step(); clear_ex();
        dmem_gnt = 1;
        step();
        dmem_gnt = 0;
        chk("rw_stall", 64'(stall), 64'd1);
        chk("rw_req", 64'(dmem_req), 64'd0);
        rst = 1;
        step();
        rst = 0;
        dmem_rvalid = 1; dmem_rdata = 64'hBEEF;
        #1;
        chk("rw_stall_after", 64'(stall), 64'd0);
        chk("rw_wb_valid", 64'(wb_valid), 64'd0);
        step();
        dmem_rvalid = 0; dmem_rdata = '0;
        chk("rw_wb_valid2", 64'(wb_valid), 64'd0);
        chk("rw_wb_rdata", wb_read_data, 64'd0);
        chk("rw_req2", 64'(dmem_req), 64'd0);

        // Load then store back-to-back
        drive(64'h60, 0, 0, 0, 5'd6, 1, 0, 1, 1, 0, 0);
        push(5'd6, 64'h60, 1, 1, 64'hCAFE);
        step();
        drive(64'h68, 0, 0, 64'h55, 5'd0, 0, 1, 0, 0, 0, 0);
        push(5'd0, 64'h68, 0, 0, 0);
        dmem_gnt = 1;
        #1;
        chk("bb_ld_req", 64'(dmem_req), 64'd1);
        chk("bb_ld_addr", dmem_addr, 64'h60);
        step();
        dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 64'hCAFE;
        #1;
        chk("bb_ld_req_wait", 64'(dmem_req), 64'd0);
        chk("bb_ld_stall", 64'(stall), 64'd0);
        step(); clear_ex();
        dmem_rvalid = 0; dmem_rdata = '0; dmem_gnt = 1;
        #1;
        chk("bb_st_req", 64'(dmem_req), 64'd1);
        chk("bb_st_we", 64'(dmem_we), 64'd1);
        chk("bb_st_addr", dmem_addr, 64'h68);
        chk("bb_st_wdata", dmem_wdata, 64'h55);
        step();
        dmem_gnt = 0;
        step(); step();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage LEGv8 pipeline, directly downstream of the execute stage. Holds the EX/MEM pipeline register, resolves conditional/unconditional branches from the execute stage's zero flag and branch target, runs a request/grant/response handshake to data memory for loads and stores, and produces the MEM/WB register contents for write-back. Stalls upstream stages while a memory access is outstanding.

## Interface
- DATA_W, 64, datapath width
- REG_W, 5, register index width
- clk  in  1  rising-edge clock
- rst  in  1  reset: one clock, synchronous, active-high
- ex_valid  in  1  execute stage holds a valid instruction
- ALUResult  in  DATA_W  execute ALU result (memory address for loads/stores)
- Zero  in  1  execute ALU zero flag
- AddResult  in  DATA_W  branch target from execute
- StoreData  in  DATA_W  register value to store
- ex_rd  in  REG_W  destination register
- MemRead, MemWrite, MemtoReg, RegWrite, Branch, UncondBranch  in  1 each  control bits
- stall  out  1  hold PC, IF/ID, ID/EX and execute inputs
- PCSrc  out  1  redirect PC to BranchTarget; flush IF/ID and ID/EX
- BranchTarget  out  DATA_W  registered AddResult
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr, dmem_wdata  out  DATA_W  address, store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  DATA_W  read data
- wb_valid, wb_RegWrite, wb_MemtoReg  out  1  MEM/WB valid and controls
- wb_rd  out  REG_W  MEM/WB destination
- wb_alu_result, wb_read_data  out  DATA_W  MEM/WB data

## Operation
- EX/MEM register (m_*) loads all execute inputs when stall=0; holds when stall=1. If PCSrc=1, loads m_valid=0 (wrong-path squash).
- m_memop = m_valid & (m_MemRead | m_MemWrite). MemRead and MemWrite never both set.
- FSM states IDLE, WAIT_RESP.
  - IDLE: dmem_req = m_memop; dmem_we = m_MemWrite; addr = m_ALUResult; wdata = m_StoreData. req&gnt&write -> done, stay IDLE. req&gnt&read -> WAIT_RESP. No gnt -> stay, req held, addr/wdata stable.
  - WAIT_RESP: dmem_req=0; rvalid -> done, rdata captured into wb_read_data, -> IDLE.
  - dmem_rvalid in IDLE ignored.
- done: write granted or read response received. stall = m_memop & ~done.
- PCSrc = m_valid & (UncondBranch | (Branch & Zero)), combinational from m_*; BranchTarget = m_AddResult. Branches never stall, so PCSrc is high exactly one cycle per taken branch.
- MEM/WB register updates every cycle: wb_valid = m_valid & ~stall; controls/rd/alu_result copied from m_*; wb_read_data updates only on rvalid. wb_RegWrite forced 0 when wb_valid=0.

## Timing
- Reset: m_valid=0, state IDLE, all wb_* outputs 0, dmem_req=0, stall=0, PCSrc=0.
- ALU op / branch: 1 cycle in stage, no stall.
- Store: 1 cycle if gnt with req; +1 cycle per gnt-low cycle.
- Load: min 2 cycles (gnt cycle, rvalid cycle); stall high until rvalid cycle inclusive-low (stall drops combinationally in the rvalid cycle).
- Reset during WAIT_RESP: state -> IDLE, m_valid -> 0 next edge; late rvalid discarded.
- Stall and PCSrc never both high (branch is never a memop).

## Structure
- Shared package pipeline_pkg: DATA_W/REG_W constants, mem_state_t enum {IDLE, WAIT_RESP}, ex_mem_ctrl_t struct of the six control bits.
- One sub-module: dmem_handshake_fsm (state, dmem_req/we, done, rdata capture enable); register and branch logic in mem_stage.

## Test plan
- ADD, ALUResult=0x10, rd=3, RegWrite=1 -> next cycle wb_valid=1, wb_alu_result=0x10, wb_rd=3, stall never high.
- LDUR addr 0x40, gnt after 2 cycles, rvalid 3 cycles later, rdata=0xDEAD -> stall high 5 cycles, addr 0x40 stable while req, wb_read_data=0xDEAD, wb_MemtoReg=1.
- STUR addr 0x80 data 0x1234, gnt immediate -> one cycle req, dmem_we=1, wdata=0x1234, no stall.
- CBZ Zero=1, AddResult=0x200 -> PCSrc=1 one cycle, BranchTarget=0x200, following ex_valid instruction squashed (wb_valid=0 for it); Zero=0 -> PCSrc stays 0.
- rst asserted in WAIT_RESP, rvalid arrives after -> all outputs at reset values, no wb_valid pulse.
- Load then store back-to-back, gnt immediate, rvalid next -> store req appears cycle after load's rvalid, both retire in order.
